acc_integ_ctrl: RTL and testbench

Integration scheduler for the power-spectrum accumulator. It sits between the FFT/power stage output and the accumulator. It arms the accumulator on a clean spectrum boundary, forwards the gated bin stream, and applies the host-written integration count only between integrations. It also counts spectra per integration, signals each completed integration, and handles start/stop requests from the control registers.

---
 rtl/acc_integ_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_acc_integ_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_integ_ctrl.sv
// acc_integ_ctrl: integration scheduler between the power stage and the
// spectrum accumulator. It arms the accumulator on a spectrum boundary,
// forwards the gated bin stream, applies host counts only between
// integrations, counts completed integrations and handles start/stop.
// Optional feature: define ACC_INTEG_CTRL_FRAME_CHECK_EN to enable bin index
// continuity checking with a sticky err_frame flag. It is off by default.
module acc_integ_ctrl #(
    parameter int BITWIDTH  = 7,
    parameter int FFT_POINT = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           cfg_num_acc,
    input  logic                  cfg_wr,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  en_sync_in,
    input  logic [BITWIDTH+1:0]   cnt_sync_in,
    output logic                  acc_rst,
    output logic [15:0]           acc_num_acc,
    output logic                  acc_en,
    output logic [BITWIDTH+1:0]   acc_cnt,
    output logic                  busy,
    output logic                  cfg_pending,
    output logic                  dump_valid,
    output logic [31:0]           dump_cnt,
    output logic                  err_frame
);

    localparam int CW = BITWIDTH + 2;
    localparam logic [CW-1:0] LAST_IDX = CW'(FFT_POINT - 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t        state, state_nxt;
    logic [15:0]   spec_cnt, spec_cnt_nxt;
    logic          stop_req, stop_req_nxt;
    logic [15:0]   pend_num, pend_num_nxt;
    logic          pending_nxt;
    logic [15:0]   num_nxt;
    logic          en_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          dump_valid_nxt;
    logic [31:0]   dump_cnt_nxt;
    logic          frame_bad;
    logic          last;

    assign last = en_sync_in && (cnt_sync_in == LAST_IDX);

`ifdef ACC_INTEG_CTRL_FRAME_CHECK_EN
    logic          err_nxt;
    logic          have_prev, have_prev_nxt;
    logic [CW-1:0] prev_idx, prev_idx_nxt;
    logic [CW-1:0] next_idx;

    assign next_idx = (prev_idx == LAST_IDX) ? '0 : prev_idx + 1'b1;
`else
    assign err_frame = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and next-output logic for all registered outputs.
    always_comb begin
        state_nxt      = state;
        spec_cnt_nxt   = spec_cnt;
        stop_req_nxt   = stop_req;
        pend_num_nxt   = pend_num;
        pending_nxt    = cfg_pending;
        num_nxt        = acc_num_acc;
        en_nxt         = 1'b0;
        cnt_nxt        = '0;
        dump_valid_nxt = 1'b0;
        dump_cnt_nxt   = dump_cnt;
        frame_bad      = 1'b0;
`ifdef ACC_INTEG_CTRL_FRAME_CHECK_EN
        err_nxt        = err_frame;
        have_prev_nxt  = have_prev;
        prev_idx_nxt   = prev_idx;
`endif
        case (state)
            IDLE: begin
                if (cfg_wr) begin
                    num_nxt     = cfg_num_acc;
                    pending_nxt = 1'b0;
                end
                if (start && !stop) begin
                    state_nxt    = ARM;
                    dump_cnt_nxt = '0;
`ifdef ACC_INTEG_CTRL_FRAME_CHECK_EN
                    err_nxt      = 1'b0;
`endif
                end
            end
            ARM: begin
                if (stop) begin
                    state_nxt    = IDLE;
                    stop_req_nxt = 1'b0;
                end else if (last) begin
                    state_nxt    = RUN;
                    spec_cnt_nxt = '0;
`ifdef ACC_INTEG_CTRL_FRAME_CHECK_EN
                    have_prev_nxt = 1'b0;
`endif
                end
                if (cfg_wr) begin
                    pend_num_nxt = cfg_num_acc;
                    pending_nxt  = 1'b1;
                end
            end
            RUN: begin
                en_nxt  = en_sync_in;
                cnt_nxt = cnt_sync_in;
`ifdef ACC_INTEG_CTRL_FRAME_CHECK_EN
                if (en_sync_in) begin
                    have_prev_nxt = 1'b1;
                    prev_idx_nxt  = cnt_sync_in;
                    if (have_prev && cnt_sync_in != next_idx) frame_bad = 1'b1;
                end
                if (frame_bad) begin
                    err_nxt      = 1'b1;
                    state_nxt    = ARM;
                    spec_cnt_nxt = '0;
                end
`endif
                if (!frame_bad && last) begin
                    if (spec_cnt != acc_num_acc) begin
                        spec_cnt_nxt = spec_cnt + 16'd1;
                    end else begin
                        dump_valid_nxt = 1'b1;
                        dump_cnt_nxt   = dump_cnt + 32'd1;
                        spec_cnt_nxt   = '0;
                        if (stop_req) begin
                            state_nxt    = IDLE;
                            stop_req_nxt = 1'b0;
                        end else if (cfg_pending) begin
                            num_nxt     = pend_num;
                            pending_nxt = 1'b0;
                            state_nxt   = ARM;
                        end
                    end
                end
                // Writes and stops seen on a boundary cycle are handled after
                // the boundary so they take effect at the following one.
                if (cfg_wr) begin
                    pend_num_nxt = cfg_num_acc;
                    pending_nxt  = 1'b1;
                end
                if (stop && state_nxt != IDLE) stop_req_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs and internal bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_cnt    <= '0;
            stop_req    <= 1'b0;
            pend_num    <= '0;
            cfg_pending <= 1'b0;
            acc_num_acc <= '0;
            acc_rst     <= 1'b1;
            acc_en      <= 1'b0;
            acc_cnt     <= '0;
            busy        <= 1'b0;
            dump_valid  <= 1'b0;
            dump_cnt    <= '0;
`ifdef ACC_INTEG_CTRL_FRAME_CHECK_EN
            err_frame   <= 1'b0;
            have_prev   <= 1'b0;
            prev_idx    <= '0;
`endif
        end else begin
            spec_cnt    <= spec_cnt_nxt;
            stop_req    <= stop_req_nxt;
            pend_num    <= pend_num_nxt;
            cfg_pending <= pending_nxt;
            acc_num_acc <= num_nxt;
            acc_rst     <= (state_nxt != RUN);
            acc_en      <= en_nxt;
            acc_cnt     <= cnt_nxt;
            busy        <= (state_nxt != IDLE);
            dump_valid  <= dump_valid_nxt;
            dump_cnt    <= dump_cnt_nxt;
`ifdef ACC_INTEG_CTRL_FRAME_CHECK_EN
            err_frame   <= err_nxt;
            have_prev   <= have_prev_nxt;
            prev_idx    <= prev_idx_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_acc_integ_ctrl.sv
// Testbench for acc_integ_ctrl: randomized bin stream with control events,
// a spectrum-level reference model feeding a scoreboard queue, and a monitor
// comparing every output each cycle. Honours ACC_INTEG_CTRL_FRAME_CHECK_EN.
module tb_acc_integ_ctrl;

    localparam int BW  = 7;
    localparam int FFT = 512;
    localparam int CW  = BW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   cfg_num_acc = '0;
    logic          cfg_wr = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          en_sync_in = 1'b0;
    logic [CW-1:0] cnt_sync_in = '0;
    logic          acc_rst, acc_en, busy, cfg_pending, dump_valid, err_frame;
    logic [15:0]   acc_num_acc;
    logic [CW-1:0] acc_cnt;
    logic [31:0]   dump_cnt;

    acc_integ_ctrl #(.BITWIDTH(BW), .FFT_POINT(FFT)) dut (
        .clk(clk), .rst(rst), .cfg_num_acc(cfg_num_acc), .cfg_wr(cfg_wr),
        .start(start), .stop(stop), .en_sync_in(en_sync_in),
        .cnt_sync_in(cnt_sync_in), .acc_rst(acc_rst), .acc_num_acc(acc_num_acc),
        .acc_en(acc_en), .acc_cnt(acc_cnt), .busy(busy),
        .cfg_pending(cfg_pending), .dump_valid(dump_valid),
        .dump_cnt(dump_cnt), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_o;
        logic [15:0]   num;
        logic          en_o;
        logic [CW-1:0] cnt_o;
        logic          busy;
        logic          pend;
        logic          dv;
        logic [31:0]   dcnt;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_dv = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: tracks mode and spectra remaining in the integration.
    int          m_mode = 0;       // 0 idle, 1 armed, 2 running
    logic [15:0] m_num = '0, m_pend = '0;
    bit          m_pending = 0, m_stopreq = 0, m_err = 0;
    int          m_left = 0;
    logic [31:0] m_dumps = '0;
    int          m_expect = -1;

    always @(posedge clk) begin
        exp_t e;
        bit   last, dv, fe;
        int   prev_mode;
        prev_mode = m_mode;
        dv = 0;
        fe = 0;
        if (rst) begin
            m_mode = 0; m_num = '0; m_pend = '0; m_pending = 0; m_stopreq = 0;
            m_err = 0; m_dumps = '0; m_left = 0; m_expect = -1;
        end else begin
            last = en_sync_in && (int'(cnt_sync_in) == FFT - 1);
            if (m_mode == 0) begin
                if (cfg_wr) begin m_num = cfg_num_acc; m_pending = 0; end
                if (start && !stop) begin m_mode = 1; m_err = 0; m_dumps = '0; end
            end else if (m_mode == 1) begin
                if (stop) begin m_mode = 0; m_stopreq = 0; end
                else if (last) begin m_mode = 2; m_left = int'(m_num) + 1; m_expect = -1; end
                if (cfg_wr) begin m_pend = cfg_num_acc; m_pending = 1; end
            end else begin
`ifdef ACC_INTEG_CTRL_FRAME_CHECK_EN
                if (en_sync_in && m_expect >= 0 && int'(cnt_sync_in) != m_expect) begin
                    fe = 1; m_err = 1; m_mode = 1;
                end
                if (en_sync_in) m_expect = (int'(cnt_sync_in) + 1) % FFT;
`endif
                if (!fe && last) begin
                    m_left--;
                    if (m_left == 0) begin
                        dv = 1;
                        m_dumps = m_dumps + 32'd1;
                        if (m_stopreq) begin m_mode = 0; m_stopreq = 0; end
                        else if (m_pending) begin m_num = m_pend; m_pending = 0; m_mode = 1; end
                        else m_left = int'(m_num) + 1;
                    end
                end
                if (cfg_wr) begin m_pend = cfg_num_acc; m_pending = 1; end
                if (stop && m_mode != 0) m_stopreq = 1;
            end
        end
        e.rst_o = (m_mode != 2);
        e.num   = m_num;
        e.en_o  = !rst && prev_mode == 2 && en_sync_in;
        e.cnt_o = (!rst && prev_mode == 2) ? cnt_sync_in : '0;
        e.busy  = (m_mode != 0);
        e.pend  = m_pending;
        e.dv    = dv;
        e.dcnt  = m_dumps;
        e.err   = m_err;
        sb.push_back(e);
    end

    // Monitor: compares DUT outputs against queued expectations.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("acc_rst", 32'(acc_rst), 32'(e.rst_o));
            check("acc_num_acc", 32'(acc_num_acc), 32'(e.num));
            check("acc_en", 32'(acc_en), 32'(e.en_o));
            if (e.en_o) check("acc_cnt", 32'(acc_cnt), 32'(e.cnt_o));
            check("busy", 32'(busy), 32'(e.busy));
            check("cfg_pending", 32'(cfg_pending), 32'(e.pend));
            check("dump_valid", 32'(dump_valid), 32'(e.dv));
            check("dump_cnt", dump_cnt, e.dcnt);
            check("err_frame", 32'(err_frame), 32'(e.err));
            if (dump_valid === 1'b1) n_dv++;
        end
    end

    task automatic drive(input logic e, input logic [CW-1:0] c, input logic w,
                         input logic [15:0] v, input logic s, input logic p, input logic r);
        en_sync_in = e; cnt_sync_in = c; cfg_wr = w; cfg_num_acc = v;
        start = s; stop = p; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic w, input logic [15:0] v, input logic s, input logic p, input logic r);
        drive(1'b0, CW'($urandom), w, v, s, p, r);
    endtask

    task automatic bin(input int b);
        drive(1'b1, CW'(b), 1'b0, 16'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    // ev: 1 cfg_wr(val), 2 stop, 3 start, 4 start+stop, 5 rst
    task automatic spectra(input int n, input int gap_pct, input int ev, input int ev_spec,
                           input int ev_bin, input logic [15:0] val);
        for (int s = 0; s < n; s++) begin
            for (int b = 0; b < FFT; b++) begin
                while (int'($urandom_range(99)) < gap_pct)
                    idle(1'b0, '0, 1'b0, 1'b0, 1'b0);
                if (ev != 0 && s == ev_spec && b == ev_bin)
                    drive(1'b1, CW'(b), ev == 1, val, ev == 3 || ev == 4,
                          ev == 2 || ev == 4, ev == 5);
                else
                    bin(b);
            end
        end
    endtask

    int dv0;

    initial begin
        // Reset
        repeat (3) idle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("reset_acc_rst", 32'(acc_rst), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);

        // Configuration load: count 3, integrations of 4 spectra
        idle(1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
        idle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        spectra(13, 10, 0, 0, 0, '0);
        check("load_dump_cnt", dump_cnt, 32'd3);
        check("load_dump_valid", 32'(dump_valid), 32'd1);

        // Mid-run reconfiguration to 1 during the 2nd spectrum
        spectra(9, 5, 1, 1, 100, 16'd1);
        check("reconf_dump_cnt", dump_cnt, 32'd6);
        check("reconf_num", 32'(acc_num_acc), 32'd1);

        // Stop during an integration
        spectra(2, 5, 2, 0, 300, '0);
        idle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_acc_rst", 32'(acc_rst), 32'd1);
        check("stop_acc_en", 32'(acc_en), 32'd0);
        check("stop_dump_cnt", dump_cnt, 32'd7);

        // Minimum count; start+stop together stays idle
        idle(1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        idle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("startstop_busy", 32'(busy), 32'd0);
        idle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        dv0 = n_dv;
        spectra(5, 5, 0, 0, 0, '0);
        idle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("min_dump_cnt", dump_cnt, 32'd4);
        check("min_dv_pulses", 32'(n_dv - dv0), 32'd4);

        // Randomized control events
        for (int i = 0; i < 16; i++) begin
            int ev;
            ev = int'($urandom_range(0, 9));
            if (ev > 5) ev = 0;
            spectra(1, int'($urandom_range(0, 30)), ev, 0, int'($urandom_range(0, FFT - 1)),
                    16'($urandom_range(0, 2)));
        end

        // Framing: skip bin 201 while running
        idle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 16'd1, 1'b0, 1'b0, 1'b0);
        idle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        spectra(2, 0, 0, 0, 0, '0);
        for (int b = 0; b <= 200; b++) bin(b);
        bin(202);
`ifdef ACC_INTEG_CTRL_FRAME_CHECK_EN
        check("frame_err", 32'(err_frame), 32'd1);
        check("frame_acc_rst", 32'(acc_rst), 32'd1);
`else
        check("frame_err", 32'(err_frame), 32'd0);
        check("frame_acc_rst", 32'(acc_rst), 32'd0);
`endif
        for (int b = 203; b < FFT; b++) bin(b);
        check("frame_restart_acc_rst", 32'(acc_rst), 32'd0);
        idle(1'b0, '0, 1'b1, 1'b0, 1'b0);
`ifdef ACC_INTEG_CTRL_FRAME_CHECK_EN
        check("frame_err_sticky", 32'(err_frame), 32'd1);
`else
        check("frame_err_sticky", 32'(err_frame), 32'd0);
`endif

        // Reset mid-run drops pending configuration
        idle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 16'd1, 1'b0, 1'b0, 1'b0);
        idle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        spectra(2, 0, 1, 1, 10, 16'd2);
        check("pre_rst_pending", 32'(cfg_pending), 32'd1);
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("midrst_acc_rst", 32'(acc_rst), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pending", 32'(cfg_pending), 32'd0);
        check("midrst_num", 32'(acc_num_acc), 32'd0);
        check("midrst_dump_cnt", dump_cnt, 32'd0);
        check("midrst_acc_en", 32'(acc_en), 32'd0);

        repeat (3) idle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
